// File: rtl/demux_eight_stream_pkg.sv
// Shared constants, channel mask type and select decoder for the 1-to-8 stream demux.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [NUM_CH-1:0] ch_mask_t;

  function automatic ch_mask_t sel_onehot(input logic [SEL_W-1:0] select);
    ch_mask_t mask;
    mask         = '0;
    mask[select] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_eight_stream_if.sv
// Producer bus plus eight consumer channels; signal directions are named from the demux side.
interface demux_eight_stream_if #(
  parameter int BITS  = 2,
  parameter int CNT_W = 8
);
  import demux_pkg::*;

  logic [BITS-1:0]                bus_i;
  logic [SEL_W-1:0]               select_i;
  logic                           valid_i;
  logic                           ready_o;
  logic [NUM_CH-1:0][BITS-1:0]    bus_o;
  logic [NUM_CH-1:0]              valid_o;
  logic [NUM_CH-1:0]              ready_i;
  logic [NUM_CH-1:0][CNT_W-1:0]   count_o;

  modport slave (
    input  bus_i, select_i, valid_i, ready_i,
    output ready_o, bus_o, valid_o, count_o
  );

  modport master (
    output bus_i, select_i, valid_i, ready_i,
    input  ready_o, bus_o, valid_o, count_o
  );

endinterface

// File: rtl/demux_eight_stream_slot.sv
// One-entry holding slot for a single output channel, with its delivered-word counter.
module demux_slot #(
  parameter int BITS  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic [BITS-1:0]  data_i,
  input  logic             ready_i,
  output logic [BITS-1:0]  data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [BITS-1:0]  data_q,  data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  assign drain = valid_q & ready_i;

  // A load wins over drain/flush so a word arriving as the old one leaves keeps the slot full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (drain) begin
      count_d = count_q + 1'b1;
    end
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (flush_i || drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/demux_eight_stream.sv
// Registered 1-to-8 stream demux: decodes select, gates ready on the addressed slot, fans out to slots.
module demux_eight_stream
  import demux_pkg::*;
#(
  parameter int BITS  = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  demux_eight_stream_if.slave  dif
);

  ch_mask_t sel_mask;
  ch_mask_t load;
  ch_mask_t valid_w;
  logic     sel_free;
  logic     accept;

  assign sel_mask = sel_onehot(dif.select_i);

  // Ready looks only at the addressed slot, never at valid_i, so a stalled channel blocks only itself.
  assign sel_free    = ~valid_w[dif.select_i] | dif.ready_i[dif.select_i];
  assign dif.ready_o = sel_free & ~flush_i;
  assign accept      = dif.valid_i & dif.ready_o;
  assign load        = sel_mask & {NUM_CH{accept}};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      demux_slot #(
        .BITS  (BITS),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load[gi]),
        .flush_i (flush_i),
        .data_i  (dif.bus_i),
        .ready_i (dif.ready_i[gi]),
        .data_o  (dif.bus_o[gi]),
        .valid_o (valid_w[gi]),
        .count_o (dif.count_o[gi])
      );
    end
  endgenerate

  assign dif.valid_o = valid_w;

endmodule

// File: tb/tb_demux_eight_stream.sv
// Directed and random traffic against two demux instances (8-bit and 2-bit counters) and a slot model.
module tb_demux_eight_stream;

  logic       clk;
  logic       rst_n;
  logic       tb_flush;
  logic [1:0] tb_bus;
  logic [2:0] tb_sel;
  logic       tb_valid;
  logic [7:0] tb_rdy;

  int tests_run;
  int tests_failed;

  // Behavioural view: each channel is either empty or holds one word; counts are unbounded integers.
  logic       mv [8];
  logic [1:0] md [8];
  int         mc [8];

  demux_eight_stream_if #(.BITS(2), .CNT_W(8)) if8 ();
  demux_eight_stream_if #(.BITS(2), .CNT_W(2)) if2 ();

  assign if8.bus_i    = tb_bus;
  assign if8.select_i = tb_sel;
  assign if8.valid_i  = tb_valid;
  assign if8.ready_i  = tb_rdy;
  assign if2.bus_i    = tb_bus;
  assign if2.select_i = tb_sel;
  assign if2.valid_i  = tb_valid;
  assign if2.ready_i  = tb_rdy;

  demux_eight_stream #(.BITS(2), .CNT_W(8)) dut8 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (tb_flush),
    .dif     (if8.slave)
  );

  demux_eight_stream #(.BITS(2), .CNT_W(2)) dut2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (tb_flush),
    .dif     (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0;
      md[k] = 2'b00;
      mc[k] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0]  ev;
    logic [15:0] eb;
    logic [63:0] ec8;
    logic [15:0] ec2;
    ev = '0; eb = '0; ec8 = '0; ec2 = '0;
    for (int k = 0; k < 8; k++) begin
      ev[k]         = mv[k];
      eb[k*2 +: 2]  = md[k];
      ec8[k*8 +: 8] = mc[k] % 256;
      ec2[k*2 +: 2] = mc[k] % 4;
    end
    check({tag, ".valid8"}, 64'(if8.valid_o), 64'(ev));
    check({tag, ".bus8"},   64'(if8.bus_o),   64'(eb));
    check({tag, ".count8"}, 64'(if8.count_o), ec8);
    check({tag, ".valid2"}, 64'(if2.valid_o), 64'(ev));
    check({tag, ".count2"}, 64'(if2.count_o), 64'(ec2));
  endtask

  // One clock cycle: drive inputs just after a falling edge, check ready, advance model, check state.
  task automatic cyc(input string tag, input logic f, input logic [1:0] b, input logic [2:0] s,
                     input logic v, input logic [7:0] r);
    logic exp_rdy;
    tb_flush = f; tb_bus = b; tb_sel = s; tb_valid = v; tb_rdy = r;
    #1;
    exp_rdy = f ? 1'b0 : (!mv[s] || r[s]);
    check({tag, ".ready8"}, 64'(if8.ready_o), 64'(exp_rdy));
    check({tag, ".ready2"}, 64'(if2.ready_o), 64'(exp_rdy));
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      logic leaving;
      leaving = mv[k] && r[k];
      if (leaving) mc[k]++;
      if (v && exp_rdy && (s == 3'(k))) begin
        md[k] = b;
        mv[k] = 1'b1;
      end else if (f || leaving) begin
        mv[k] = 1'b0;
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    tb_flush = 1'b0; tb_bus = 2'b00; tb_sel = 3'd0; tb_valid = 1'b0; tb_rdy = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset.ready", 64'(if8.ready_o), 64'd1);
    rst_n = 1'b1;

    // First load: one word to channel 5, one-cycle latency.
    cyc("load5", 1'b0, 2'b10, 3'd5, 1'b1, 8'h00);
    check("load5.valid_const", 64'(if8.valid_o), 64'h20);
    check("load5.bus_const", 64'(if8.bus_o[5]), 64'h2);

    // Channel 5 stalled: second word waits, then swaps in as the old word drains.
    cyc("stall5a", 1'b0, 2'b01, 3'd5, 1'b1, 8'h00);
    check("stall5a.ready_const", 64'(if8.ready_o), 64'd0);
    cyc("stall5b", 1'b0, 2'b01, 3'd5, 1'b1, 8'h00);
    cyc("swap5", 1'b0, 2'b01, 3'd5, 1'b1, 8'h20);
    check("swap5.count_const", 64'(if8.count_o[5]), 64'd1);
    check("swap5.bus_const", 64'(if8.bus_o[5]), 64'h1);

    // Full-throughput stream on channel 2.
    cyc("strm1", 1'b0, 2'd1, 3'd2, 1'b1, 8'h04);
    cyc("strm2", 1'b0, 2'd2, 3'd2, 1'b1, 8'h04);
    cyc("strm3", 1'b0, 2'd3, 3'd2, 1'b1, 8'h04);
    cyc("strm0", 1'b0, 2'd0, 3'd2, 1'b1, 8'h04);
    cyc("strmd", 1'b0, 2'd0, 3'd2, 1'b0, 8'h04);
    check("strm.count_const", 64'(if8.count_o[2]), 64'd4);

    // Clear, then stall channel 0 while filling channels 1..7 back-to-back.
    cyc("clr", 1'b1, 2'd0, 3'd0, 1'b0, 8'h00);
    cyc("fill0", 1'b0, 2'b11, 3'd0, 1'b1, 8'h00);
    for (int k = 1; k < 8; k++) begin
      cyc("fillk", 1'b0, 2'(k), 3'(k), 1'b1, 8'h00);
    end
    check("fill.valid_const", 64'(if8.valid_o), 64'hFF);
    check("fill.ch0_const", 64'(if8.bus_o[0]), 64'h3);

    // Flush with a pending word: nothing loads, data and counters survive.
    cyc("flush", 1'b1, 2'b01, 3'd3, 1'b1, 8'h00);
    check("flush.valid_const", 64'(if8.valid_o), 64'h00);

    // Five deliveries on channel 7 wrap the 2-bit counter to 1.
    cyc("w7l", 1'b0, 2'd1, 3'd7, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc("w7s", 1'b0, 2'(i), 3'd7, 1'b1, 8'h80);
    end
    cyc("w7d", 1'b0, 2'd0, 3'd7, 1'b0, 8'h80);
    check("wrap.count2_const", 64'(if2.count_o[7]), 64'd1);

    // Random traffic, including protocol-violating select changes, which follow the same equations.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 24) == 0), 2'($urandom), 3'($urandom),
          1'($urandom), 8'($urandom));
    end

    // Asynchronous reset in the middle of traffic.
    cyc("pre_rst", 1'b0, 2'd2, 3'd4, 1'b1, 8'h0F);
    tb_valid = 1'b1; tb_sel = 3'd6;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    check("async_rst.valid_const", 64'(if8.valid_o), 64'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 1'b0, 2'b11, 3'd1, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
